// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states,
// instruction field positions and the LI immediate extension helper.
package regfile_seq_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LI   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_HALTED
    } state_t;

    // Instruction field positions
    localparam int unsigned OP_MSB    = 7;
    localparam int unsigned OP_LSB    = 6;
    localparam int unsigned RS_MSB    = 5;
    localparam int unsigned RS_LSB    = 4;
    localparam int unsigned RT_MSB    = 3;
    localparam int unsigned RT_LSB    = 2;
    localparam int unsigned RD_MSB    = 1;
    localparam int unsigned RD_LSB    = 0;
    localparam int unsigned LI_RD_MSB = 5;
    localparam int unsigned LI_RD_LSB = 4;
    localparam int unsigned IMM_MSB   = 3;
    localparam int unsigned IMM_LSB   = 0;

    // Sign-extend the 4-bit LI immediate to a full data word
    function automatic logic [7:0] sext_imm4(input logic [3:0] imm);
        return {{4{imm[3]}}, imm};
    endfunction

endpackage

// File: rtl/regfile_sequencer_alu8.sv
// 8-bit add/subtract unit. carry is the carry-out for add and the borrow
// (a < b unsigned) for subtract.
module alu8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       op_sub,
    output logic [7:0] result,
    output logic       carry
);

    logic [8:0] w_sum;

    // Nine-bit add/sub; bit 8 is carry-out or borrow
    always_comb begin
        if (op_sub) begin
            w_sum = {1'b0, a} - {1'b0, b};
        end else begin
            w_sum = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = w_sum[7:0];
    assign carry  = w_sum[8];

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer for the 4 x 8-bit register file. Accepts one
// instruction per valid/ready handshake, reads operands for one cycle,
// writes the result for one cycle, then retires it.
module regfile_sequencer
    import regfile_seq_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       resume,
    input  logic [7:0] reg_data1,
    input  logic [7:0] reg_data2,
    output logic [1:0] read_reg1,
    output logic [1:0] read_reg2,
    output logic [1:0] write_reg,
    output logic [7:0] write_data,
    output logic       signal_regwrite,
    output logic       busy,
    output logic       done,
    output logic       halted,
    output logic       carry,
    output logic [7:0] retired_count
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_ir;
    logic [7:0] r_result;
    logic [7:0] r_count;
    logic [1:0] r_rd1;
    logic [1:0] r_rd2;
    logic [1:0] r_wreg;
    logic       r_carry;
    logic       r_done;

    logic       w_xfer;
    logic       w_in_halt;
    logic [1:0] w_ir_op;
    logic       w_ir_li;
    logic [7:0] w_alu_res;
    logic       w_alu_c;
    logic [7:0] w_result;

    assign w_in_halt = (instr[OP_MSB:OP_LSB] == OP_HALT);
    assign w_ir_op   = r_ir[OP_MSB:OP_LSB];
    assign w_ir_li   = (w_ir_op == OP_LI);

    alu8 u_alu (
        .a      (reg_data1),
        .b      (reg_data2),
        .op_sub (w_ir_op == OP_SUB),
        .result (w_alu_res),
        .carry  (w_alu_c)
    );

    // Select ALU output or the extended LI immediate as the result
    always_comb begin
        w_result = w_alu_res;
        if (w_ir_li) begin
            w_result = sext_imm4(r_ir[IMM_MSB:IMM_LSB]);
        end
    end

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next          = r_state;
        w_xfer          = 1'b0;
        instr_ready     = 1'b0;
        busy            = 1'b0;
        halted          = 1'b0;
        signal_regwrite = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_xfer = 1'b1;
                    w_next = w_in_halt ? ST_HALTED : ST_READ;
                end
            end
            ST_READ: begin
                busy   = 1'b1;
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy            = 1'b1;
                signal_regwrite = 1'b1;
                w_next          = ST_IDLE;
            end
            ST_HALTED: begin
                busy   = 1'b1;
                halted = 1'b1;
                if (resume) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the instruction and its read addresses on handshake; the read
    // addresses are loaded here so they are already valid throughout READ
    // and simply hold afterwards
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_ir  <= '0;
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (w_xfer) begin
            r_ir <= instr;
            if (!w_in_halt) begin
                r_rd1 <= instr[RS_MSB:RS_LSB];
                r_rd2 <= instr[RT_MSB:RT_LSB];
            end
        end
    end

    // Capture result, destination and carry at the end of READ
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_result <= '0;
            r_wreg   <= '0;
            r_carry  <= 1'b0;
        end else if (r_state == ST_READ) begin
            r_result <= w_result;
            if (w_ir_li) begin
                r_wreg <= r_ir[LI_RD_MSB:LI_RD_LSB];
            end else begin
                r_wreg  <= r_ir[RD_MSB:RD_LSB];
                r_carry <= w_alu_c;
            end
        end
    end

    // Retire: pulse done and bump the count after WRITE or a HALT transfer
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == ST_WRITE) || (w_xfer && w_in_halt)) begin
                r_done  <= 1'b1;
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign read_reg1     = r_rd1;
    assign read_reg2     = r_rd2;
    assign write_reg     = r_wreg;
    assign write_data    = r_result;
    assign carry         = r_carry;
    assign done          = r_done;
    assign retired_count = r_count;

endmodule
